// File: rtl/data_mem_pkg.sv
// Shared constants for the data RAM: access strobe encodings, zero word and FSM state encodings.
package data_mem_pkg;

  localparam logic RAM_WRITE   = 1'b1;
  localparam logic RAM_UNWRITE = 1'b0;
  localparam logic RAM_ENABLE  = 1'b1;
  localparam logic RAM_DISABLE = 1'b0;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  localparam logic [0:0] DMEM_INIT  = 1'b0;
  localparam logic [0:0] DMEM_READY = 1'b1;

  // A byte address is usable only if word aligned and inside the 2**aw word window.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned aw);
    return (a[1:0] == 2'b00) && ((a >> (aw + 2)) == ZERO);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word storage: one synchronous write port and one combinational read port.
module dmem_array #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem.sv
// Word-organised data RAM with post-reset zero-fill, alignment/range trap and, when
// DMEM_STATS_EN is defined, saturating load/store counters.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int AW         = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        init_done,
  output logic        err,
  output logic [31:0] err_addr
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
`endif
);

  logic [0:0]    state;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] idx;
  logic          ok;
  logic          ready;
  logic          rd_valid;
  logic          wr_valid;
  logic          fault;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  assign ok    = addr_ok(addr, AW);
  assign idx   = addr[AW+1:2];
  assign ready = (state == DMEM_READY);

  // Every access qualifier includes !rst so a reset cycle neither writes nor returns data.
  assign rd_valid = ready && !rst && (ce == RAM_ENABLE) && (we == RAM_UNWRITE) && ok;
  assign wr_valid = ready && !rst && (ce == RAM_ENABLE) && (we == RAM_WRITE) && ok;
  assign fault    = ready && !rst && (ce == RAM_ENABLE) && !ok;

  assign arr_we    = ready ? wr_valid : !rst;
  assign arr_waddr = ready ? idx : clr_idx;
  assign arr_wdata = ready ? wdata : ZERO;

  dmem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  assign rdata     = rd_valid ? arr_rdata : ZERO;
  assign init_done = ready;

  // Clear sequencer: one word per cycle, READY follows the cycle that wrote the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT_CLEAR ? DMEM_INIT : DMEM_READY;
      clr_idx <= '0;
    end else if (state == DMEM_INIT) begin
      clr_idx <= clr_idx + 1'b1;
      if (&clr_idx) state <= DMEM_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= ZERO;
    end else if (fault) begin
      err <= 1'b1;
      if (!err) err_addr <= addr;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= ZERO;
      st_cnt <= ZERO;
    end else begin
      if (rd_valid && (ld_cnt != 32'hFFFF_FFFF)) ld_cnt <= ld_cnt + 32'd1;
      if (wr_valid && (st_cnt != 32'hFFFF_FFFF)) st_cnt <= st_cnt + 32'd1;
    end
  end
`endif

endmodule
